// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Purpose : bundles the upstream byte stream, the load command and the
//           CPU-facing Load/data_in pins of the program loader.
// Signals :
//   start       pulse that begins a load
//   prog_len    program length in bytes (0 means a full buffer)
//   byte_valid  upstream byte present
//   byte_data   upstream byte
//   byte_ready  loader accepts a byte this cycle
//   load_out    CPU Load pin
//   data_out    CPU data_in pins
//   done        burst complete, CPU running
//   err         checksum failure
// Modports:
//   master  the side that commands the loader and watches its outputs
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface program_loader_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
);
  logic              start;
  logic [LEN_W-1:0]  prog_len;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              byte_ready;
  logic              load_out;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              err;

  modport master (
    output start, prog_len, byte_valid, byte_data,
    input  byte_ready, load_out, data_out, done, err
  );

  modport slave (
    input  start, prog_len, byte_valid, byte_data,
    output byte_ready, load_out, data_out, done, err
  );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Purpose : collects a program byte-by-byte over a valid/ready stream into a
//           local buffer, then drives it into the CPU as one contiguous Load
//           window of PROG_WORDS cycles (one word per clock), then releases
//           Load so the CPU runs and reports done.
// Ports   :
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset (assert async, release synchronised)
//   lp      program_loader_if.slave: start/prog_len/byte stream in,
//           byte_ready/load_out/data_out/done/err out (all outputs registered)
// Build option:
//   LOADER_CHECKSUM_EN  when defined, FILL takes one extra checksum byte and a
//                       one-cycle CHECK state verifies the mod-256 sum of all
//                       bytes is zero; failure parks in ERROR with err=1.
//                       When undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int PROG_WORDS = 32,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 6
) (
  input  logic               clock,
  input  logic               reset,
  program_loader_if.slave    lp
);

  localparam int AW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PROG_WORDS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_BURST = 3'd2,
    S_RUN   = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHECK = 3'd4,
    S_ERROR = 3'd5
`endif
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wr_cnt_q;
  logic [LEN_W-1:0]  rd_cnt_q;
  logic              byte_ready_q;
  logic              load_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
`ifdef LOADER_CHECKSUM_EN
  logic              err_q;
  logic [DATA_W-1:0] sum_q;
`endif

  // Program buffer: deliberately not reset, contents beyond len are never shown.
  logic [DATA_W-1:0] mem [PROG_WORDS];

  logic [1:0]        rst_sync_q;
  logic              rst_n_s;

  logic [LEN_W-1:0]  start_len_s;
  logic [LEN_W-1:0]  fill_target_s;
  logic [LEN_W-1:0]  wr_cnt_d;
  logic              start_ok_s;
  logic              xfer_s;
  logic              store_s;
  logic [DATA_W-1:0] rd_word_s;
`ifndef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] word0_s;
`endif

  // Reset synchroniser: assertion is immediate, release waits two clock edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Decode of start acceptance, byte transfer and the next buffer word.
  always_comb begin
    start_len_s   = lp.prog_len;
    fill_target_s = len_q;
    wr_cnt_d      = wr_cnt_q;
    start_ok_s    = 1'b0;
    xfer_s        = 1'b0;
    store_s       = 1'b0;
    rd_word_s     = {DATA_W{1'b0}};

    // 0 and anything larger than the buffer both mean "full buffer".
    if ((lp.prog_len == {LEN_W{1'b0}}) || (lp.prog_len > FULL_LEN)) begin
      start_len_s = FULL_LEN;
    end else begin
      start_len_s = lp.prog_len;
    end

`ifdef LOADER_CHECKSUM_EN
    // One extra byte carries the checksum.
    fill_target_s = len_q + LEN_ONE;
`else
    fill_target_s = len_q;
`endif

    if ((state_q == S_IDLE) || (state_q == S_RUN)
`ifdef LOADER_CHECKSUM_EN
        || (state_q == S_ERROR)
`endif
       ) begin
      start_ok_s = lp.start;
    end else begin
      start_ok_s = 1'b0;
    end

    xfer_s = (state_q == S_FILL) && lp.byte_valid && byte_ready_q;
    // The checksum byte (index len) is summed but never stored.
    store_s = xfer_s && (wr_cnt_q < len_q);

    // Counter saturates at its all-ones value rather than wrapping.
    if (xfer_s && (wr_cnt_q != {LEN_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + LEN_ONE;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (rd_cnt_q < len_q) begin
      rd_word_s = mem[rd_cnt_q[AW-1:0]];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

`ifndef LOADER_CHECKSUM_EN
  // Word 0 is written on the same edge as the last byte when len is 1, so it
  // must be taken straight from the stream in that case.
  assign word0_s = (wr_cnt_q == {LEN_W{1'b0}}) ? lp.byte_data : mem[0];
`endif

  // Buffer write port.
  always_ff @(posedge clock) begin
    if (store_s) begin
      mem[wr_cnt_q[AW-1:0]] <= lp.byte_data;
    end
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q      <= S_IDLE;
      len_q        <= {LEN_W{1'b0}};
      wr_cnt_q     <= {LEN_W{1'b0}};
      rd_cnt_q     <= {LEN_W{1'b0}};
      byte_ready_q <= 1'b0;
      load_q       <= 1'b0;
      data_q       <= {DATA_W{1'b0}};
      done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q        <= 1'b0;
      sum_q        <= {DATA_W{1'b0}};
`endif
    end else begin
      case (state_q)
        S_IDLE,
`ifdef LOADER_CHECKSUM_EN
        S_ERROR,
`endif
        S_RUN: begin
          if (start_ok_s) begin
            state_q      <= S_FILL;
            len_q        <= start_len_s;
            wr_cnt_q     <= {LEN_W{1'b0}};
            rd_cnt_q     <= {LEN_W{1'b0}};
            byte_ready_q <= 1'b1;
            load_q       <= 1'b0;
            data_q       <= {DATA_W{1'b0}};
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
            sum_q        <= {DATA_W{1'b0}};
`endif
          end
        end

        S_FILL: begin
          if (xfer_s) begin
            wr_cnt_q <= wr_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_q + lp.byte_data;
`endif
            if (wr_cnt_d == fill_target_s) begin
              byte_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              state_q      <= S_CHECK;
`else
              // Word 0 leaves on the same edge Load rises.
              state_q      <= S_BURST;
              load_q       <= 1'b1;
              data_q       <= word0_s;
              rd_cnt_q     <= LEN_ONE;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (sum_q == {DATA_W{1'b0}}) begin
            state_q  <= S_BURST;
            load_q   <= 1'b1;
            data_q   <= mem[0];
            rd_cnt_q <= LEN_ONE;
          end else begin
            state_q  <= S_ERROR;
            err_q    <= 1'b1;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
          end
        end
`endif

        S_BURST: begin
          // rd_cnt_q is the index of the word going out on the next edge;
          // reaching PROG_WORDS means the last word has already been shown.
          if (rd_cnt_q == FULL_LEN) begin
            state_q <= S_RUN;
            load_q  <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            done_q  <= 1'b1;
          end else begin
            data_q   <= rd_word_s;
            rd_cnt_q <= rd_cnt_q + LEN_ONE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          load_q       <= 1'b0;
          data_q       <= {DATA_W{1'b0}};
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign lp.byte_ready = byte_ready_q;
  assign lp.load_out   = load_q;
  assign lp.data_out   = data_q;
  assign lp.done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign lp.err        = err_q;
`else
  assign lp.err        = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader: reset values, a short program, a full
// program with a gapped stream and an ignored start mid-burst, a restart from
// RUN with a one-byte program, asynchronous reset mid-burst, and (when
// LOADER_CHECKSUM_EN is defined) good and bad checksum loads.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_program_loader;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] exp_mem [32];

  program_loader_if #(.DATA_W(8), .LEN_W(6)) lp ();

  program_loader #(
    .PROG_WORDS (32),
    .DATA_W     (8),
    .LEN_W      (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .lp    (lp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks a 32-cycle Load window starting at the current falling edge,
  // optionally pulsing start at word pulse_at, then checks the RUN outputs.
  task automatic run_burst(input int pulse_at, input int nlen);
    for (int k = 0; k < 32; k++) begin
      chk("burst_load", {31'd0, lp.load_out}, 32'd1);
      chk("burst_data", {24'd0, lp.data_out}, (k < nlen) ? {24'd0, exp_mem[k]} : 32'd0);
      lp.start = (k == pulse_at);
      @(negedge clock);
    end
    lp.start = 1'b0;
    chk("run_load", {31'd0, lp.load_out}, 32'd0);
    chk("run_done", {31'd0, lp.done}, 32'd1);
    chk("run_data", {24'd0, lp.data_out}, 32'd0);
    chk("run_err",  {31'd0, lp.err}, 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    lp.start      = 1'b0;
    lp.prog_len   = 6'd0;
    lp.byte_valid = 1'b0;
    lp.byte_data  = 8'h00;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;

    // Reset values.
    #12;
    chk("rst_ready", {31'd0, lp.byte_ready}, 32'd0);
    chk("rst_load",  {31'd0, lp.load_out}, 32'd0);
    chk("rst_data",  {24'd0, lp.data_out}, 32'd0);
    chk("rst_done",  {31'd0, lp.done}, 32'd0);
    chk("rst_err",   {31'd0, lp.err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_ready", {31'd0, lp.byte_ready}, 32'd0);
    chk("idle_load",  {31'd0, lp.load_out}, 32'd0);
    chk("idle_done",  {31'd0, lp.done}, 32'd0);

    // Three-byte program, back-to-back stream.
    lp.prog_len = 6'd3;
    lp.start    = 1'b1;
    @(negedge clock);
    lp.start = 1'b0;
    chk("p3_ready0", {31'd0, lp.byte_ready}, 32'd1);
    lp.byte_valid = 1'b1;
    lp.byte_data  = 8'h21;
    @(negedge clock);
    lp.byte_data  = 8'h45;
    @(negedge clock);
    chk("p3_ready2", {31'd0, lp.byte_ready}, 32'd1);
    lp.byte_data  = 8'hE3;
    @(negedge clock);
    lp.byte_valid = 1'b0;
    chk("p3_ready_low", {31'd0, lp.byte_ready}, 32'd0);
    exp_mem[0] = 8'h21;
    exp_mem[1] = 8'h45;
    exp_mem[2] = 8'hE3;
    run_burst(-1, 3);

    // Full program from RUN, byte_valid every other cycle, start at word 10.
    lp.prog_len = 6'd0;
    lp.start    = 1'b1;
    @(negedge clock);
    lp.start = 1'b0;
    chk("p32_done_clr", {31'd0, lp.done}, 32'd0);
    chk("p32_ready",    {31'd0, lp.byte_ready}, 32'd1);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'(i);
    for (int i = 0; i < 63; i++) begin
      if ((i % 2) == 0) begin
        lp.byte_valid = 1'b1;
        lp.byte_data  = 8'(i / 2);
      end else begin
        lp.byte_valid = 1'b0;
      end
      @(negedge clock);
      if ((i % 8) == 1) chk("p32_fill_ready", {31'd0, lp.byte_ready}, 32'd1);
    end
    lp.byte_valid = 1'b0;
    chk("p32_ready_low", {31'd0, lp.byte_ready}, 32'd0);
    run_burst(10, 32);

    // Restart from RUN with a one-byte program, then async reset at word 5.
    lp.prog_len = 6'd1;
    lp.start    = 1'b1;
    @(negedge clock);
    lp.start = 1'b0;
    chk("p1_done_clr", {31'd0, lp.done}, 32'd0);
    chk("p1_ready",    {31'd0, lp.byte_ready}, 32'd1);
    lp.byte_valid = 1'b1;
    lp.byte_data  = 8'h5A;
    @(negedge clock);
    lp.byte_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("p1_load", {31'd0, lp.load_out}, 32'd1);
      chk("p1_data", {24'd0, lp.data_out}, (k == 0) ? 32'h5A : 32'h00);
      @(negedge clock);
    end
    chk("p1_load5", {31'd0, lp.load_out}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_load",  {31'd0, lp.load_out}, 32'd0);
    chk("arst_data",  {24'd0, lp.data_out}, 32'd0);
    chk("arst_done",  {31'd0, lp.done}, 32'd0);
    chk("arst_ready", {31'd0, lp.byte_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_rst_load",  {31'd0, lp.load_out}, 32'd0);
    chk("post_rst_ready", {31'd0, lp.byte_ready}, 32'd0);
    chk("post_rst_done",  {31'd0, lp.done}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 0x10 + 0x20 + 0xD0 = 0x100.
    lp.prog_len = 6'd2;
    lp.start    = 1'b1;
    @(negedge clock);
    lp.start      = 1'b0;
    lp.byte_valid = 1'b1;
    lp.byte_data  = 8'h10;
    @(negedge clock);
    lp.byte_data  = 8'h20;
    @(negedge clock);
    chk("cs_ready_sum", {31'd0, lp.byte_ready}, 32'd1);
    lp.byte_data  = 8'hD0;
    @(negedge clock);
    lp.byte_valid = 1'b0;
    chk("cs_check_load", {31'd0, lp.load_out}, 32'd0);
    @(negedge clock);
    exp_mem[0] = 8'h10;
    exp_mem[1] = 8'h20;
    run_burst(-1, 2);

    // Bad checksum byte.
    lp.start = 1'b1;
    @(negedge clock);
    lp.start      = 1'b0;
    lp.byte_valid = 1'b1;
    lp.byte_data  = 8'h10;
    @(negedge clock);
    lp.byte_data  = 8'h20;
    @(negedge clock);
    lp.byte_data  = 8'hD1;
    @(negedge clock);
    lp.byte_valid = 1'b0;
    @(negedge clock);
    chk("cs_bad_err",  {31'd0, lp.err}, 32'd1);
    chk("cs_bad_load", {31'd0, lp.load_out}, 32'd0);
    chk("cs_bad_done", {31'd0, lp.done}, 32'd0);
    repeat (3) @(negedge clock);
    chk("cs_bad_hold", {31'd0, lp.load_out}, 32'd0);
    chk("cs_bad_err2", {31'd0, lp.err}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
